// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Holds the pipeline in EX via o_stall_ex until the registered result is ready.
module ex_muldiv_seq #(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    input  logic [2:0]        i_req_op,
    input  logic [DWIDTH-1:0] i_req_a,
    input  logic [DWIDTH-1:0] i_req_b,
    input  logic              i_kill,
    output logic              o_resp_valid,
    output logic [DWIDTH-1:0] o_resp_data,
    output logic              o_busy,
    output logic              o_stall_ex
);

    localparam int unsigned CW = $clog2(DWIDTH) + 1;
    localparam int unsigned PW = 2 * DWIDTH;
    localparam logic [DWIDTH-1:0] MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic [CW-1:0]     LAST_CNT = CW'(DWIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [DWIDTH-1:0] r_opnd;      // multiplicand or divisor magnitude
    logic [PW-1:0]     r_acc;       // {product hi | remainder, multiplier | quotient}
    logic              r_neg;
    logic              r_div;
    logic              r_rem;
    logic              r_hi;
    logic              r_resp_valid;
    logic [DWIDTH-1:0] r_resp_data;

    // Operand decode at accept
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [DWIDTH-1:0] w_a_mag;
    logic [DWIDTH-1:0] w_b_mag;
    logic              w_b_zero;
    logic              w_ovf;
    logic              w_fast;
    logic [DWIDTH-1:0] w_fast_data;
    logic              w_accept;

    assign w_a_signed  = i_req_op[2] ? ~i_req_op[0] : (i_req_op[1:0] != 2'b11);
    assign w_b_signed  = i_req_op[2] ? ~i_req_op[0] : ~i_req_op[1];
    assign w_a_neg     = w_a_signed & i_req_a[DWIDTH-1];
    assign w_b_neg     = w_b_signed & i_req_b[DWIDTH-1];
    assign w_a_mag     = w_a_neg ? DWIDTH'(~i_req_a + DWIDTH'(1)) : i_req_a;
    assign w_b_mag     = w_b_neg ? DWIDTH'(~i_req_b + DWIDTH'(1)) : i_req_b;
    assign w_b_zero    = (i_req_b == '0);
    assign w_ovf       = i_req_op[2] & ~i_req_op[0] & (i_req_a == MOST_NEG) & (i_req_b == '1);
    assign w_fast      = i_req_op[2] & (w_b_zero | w_ovf);
    assign w_accept    = (r_state == S_IDLE) & i_req_valid & ~i_kill;

    // Divide by zero wins over overflow (b cannot be both 0 and -1)
    always_comb begin
        w_fast_data = MOST_NEG;
        if (i_req_op[1]) begin
            w_fast_data = w_b_zero ? i_req_a : '0;
        end else if (w_b_zero) begin
            w_fast_data = '1;
        end
    end

    // One iteration step: shift-add multiply or restoring divide
    logic [DWIDTH:0]   w_sum;
    logic [DWIDTH:0]   w_shift;
    logic [DWIDTH:0]   w_diff;
    logic [PW-1:0]     w_mul_next;
    logic [PW-1:0]     w_div_next;
    logic [PW-1:0]     w_next;

    assign w_sum      = {1'b0, r_acc[PW-1:DWIDTH]} + {1'b0, r_opnd};
    assign w_mul_next = r_acc[0] ? {w_sum, r_acc[DWIDTH-1:1]} : {1'b0, r_acc[PW-1:1]};
    assign w_shift    = {r_acc[PW-1:DWIDTH], r_acc[DWIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_opnd};
    assign w_div_next = w_diff[DWIDTH]
                      ? {w_shift[DWIDTH-1:0], r_acc[DWIDTH-2:0], 1'b0}
                      : {w_diff[DWIDTH-1:0],  r_acc[DWIDTH-2:0], 1'b1};
    assign w_next     = r_div ? w_div_next : w_mul_next;

    // Final sign fix-up and result selection
    logic [PW-1:0]     w_prod;
    logic [DWIDTH-1:0] w_div_sel;
    logic [DWIDTH-1:0] w_div_res;
    logic [DWIDTH-1:0] w_result;

    assign w_prod    = r_neg ? PW'(~w_next + PW'(1)) : w_next;
    assign w_div_sel = r_rem ? w_next[PW-1:DWIDTH] : w_next[DWIDTH-1:0];
    assign w_div_res = r_neg ? DWIDTH'(~w_div_sel + DWIDTH'(1)) : w_div_sel;
    assign w_result  = r_div ? w_div_res
                     : (r_hi ? w_prod[PW-1:DWIDTH] : w_prod[DWIDTH-1:0]);

    // Sequencer FSM with registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_opnd       <= '0;
            r_acc        <= '0;
            r_neg        <= 1'b0;
            r_div        <= 1'b0;
            r_rem        <= 1'b0;
            r_hi         <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_div <= i_req_op[2];
                        r_rem <= i_req_op[2] & i_req_op[1];
                        r_hi  <= ~i_req_op[2] & (i_req_op[1:0] != 2'b00);
                        r_neg <= w_a_neg ^ (w_b_neg & ~(i_req_op[2] & i_req_op[1]));
                        r_cnt <= '0;
                        if (w_fast) begin
                            r_resp_data  <= w_fast_data;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_acc   <= {{DWIDTH{1'b0}}, w_a_mag};
                            r_opnd  <= w_b_mag;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (i_kill) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_next;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == LAST_CNT) begin
                            r_resp_data  <= w_result;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_resp_valid = r_resp_valid;
    assign o_resp_data  = r_resp_data;
    assign o_busy       = (r_state != S_IDLE);
    // Must react to req_valid in the same cycle, so this one is combinational
    assign o_stall_ex   = w_accept | (r_state == S_CALC);

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Scoreboard bench for ex_muldiv_seq: directed RV32M cases, kill/reset aborts, random ops.
module tb_ex_muldiv_seq;

    localparam logic [31:0] MOST_NEG = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        kill;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        busy;
    logic        stall_ex;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_q[$];

    ex_muldiv_seq #(.DWIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (req_valid),
        .i_req_op     (req_op),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .i_kill       (kill),
        .o_resp_valid (resp_valid),
        .o_resp_data  (resp_data),
        .o_busy       (busy),
        .o_stall_ex   (stall_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model built on wide native arithmetic
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] xa, xb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        xa = a;
        xb = b;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MOST_NEG && b == 32'hFFFF_FFFF) return MOST_NEG;
                return 32'(xa / xb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MOST_NEG && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(xa % xb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Scoreboard: every response pops one expected value
    always @(negedge clk) begin
        if (resp_valid) begin
            if (exp_q.size() == 0) check("spurious_resp", 32'(resp_valid), 32'h0);
            else check("resp_data", resp_data, exp_q.pop_front());
        end
    end

    // Issue one op, then follow it through stall, latency and DONE behaviour
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat;
        int gaps;
        logic fast;
        fast = op[2] && (b == 0 || (!op[0] && a == MOST_NEG && b == 32'hFFFF_FFFF));
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        #1;
        check({tag, "_stall_req"}, 32'(stall_ex), 32'h1);
        exp_q.push_back(exp);
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        lat  = 1;
        gaps = 0;
        while (!resp_valid && lat < 40) begin
            if (!stall_ex) gaps++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), fast ? 32'd1 : 32'd33);
        check({tag, "_stall_gaps"}, 32'(gaps), 32'h0);
        check({tag, "_stall_done"}, 32'(stall_ex), 32'h0);
        check({tag, "_busy_done"}, 32'(busy), 32'h1);
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 32'h0);
        check({tag, "_pulse"}, 32'(resp_valid), 32'h0);
        check({tag, "_held"}, resp_data, exp);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 32'h0;
        req_b     = 32'h0;
        kill      = 1'b0;
        #12;
        check("rst_valid", 32'(resp_valid), 32'h0);
        check("rst_data", resp_data, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_stall", 32'(stall_ex), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_neg",   3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh",      3'd1, MOST_NEG,       MOST_NEG,      32'h4000_0000);
        run_op("mulhu",     3'd3, MOST_NEG,       MOST_NEG,      32'h4000_0000);
        run_op("mulhsu",    3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF);
        run_op("divu",      3'd5, 32'd100,        32'd7,         32'd14);
        run_op("remu",      3'd7, 32'd100,        32'd7,         32'd2);
        run_op("div_neg",   3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run_op("rem_neg",   3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run_op("div_zero",  3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF);
        run_op("rem_zero",  3'd6, 32'd5,          32'd0,         32'd5);
        run_op("div_ovf",   3'd4, MOST_NEG,       32'hFFFF_FFFF, MOST_NEG);
        run_op("rem_ovf",   3'd6, MOST_NEG,       32'hFFFF_FFFF, 32'h0);

        // Kill at CALC cycle 10: no response may follow
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd0; req_a = 32'd9; req_b = 32'd9;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", 32'(busy), 32'h0);
        check("kill_stall", 32'(stall_ex), 32'h0);
        check("kill_valid", 32'(resp_valid), 32'h0);
        repeat (40) @(negedge clk);
        run_op("mul_after_kill", 3'd0, 32'd3, 32'd5, 32'd15);

        // kill together with req_valid in IDLE: no accept
        @(negedge clk);
        req_valid = 1'b1; kill = 1'b1; req_op = 3'd5; req_a = 32'd8; req_b = 32'd2;
        #1;
        check("killreq_stall", 32'(stall_ex), 32'h0);
        @(negedge clk);
        req_valid = 1'b0; kill = 1'b0;
        check("killreq_busy", 32'(busy), 32'h0);

        // Asynchronous reset mid-CALC discards the operation
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd5; req_a = 32'd1000; req_b = 32'd3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_data", resp_data, 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_valid", 32'(resp_valid), 32'h0);
        check("arst_stall", 32'(stall_ex), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("divu_after_rst", 3'd5, 32'd9, 32'd3, 32'd3);

        // Random ops against the reference model
        for (int i = 0; i < 12; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (i % 6 == 5) b = $urandom_range(1, 100);
            run_op("rand", op, a, b, model(op, a, b));
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
